// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction stream in, immediate stream out.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_instr;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_imm;
  logic [2:0]       o_fmt;
  logic [TAG_W-1:0] o_tag;

  // Upstream/downstream environment side.
  modport master (
    output i_valid, i_instr, i_tag, i_ready,
    input  o_ready, o_valid, o_imm, o_fmt, o_tag
  );

  // Immediate generator side.
  modport slave (
    input  i_valid, i_instr, i_tag, i_ready,
    output o_ready, o_valid, o_imm, o_fmt, o_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a one-entry skid buffer and flush.
// Decode is combinational on the input beat; outputs come straight from flops.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] FmtNone = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;
  localparam logic [2:0] FmtZ    = 3'd6;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic [31:0]      instr;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             is_shift;
  logic [31:0]      dec_imm32;
  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;

  logic             main_valid_q;
  logic [XLEN-1:0]  main_imm_q;
  logic [2:0]       main_fmt_q;
  logic [TAG_W-1:0] main_tag_q;
  logic             skid_valid_q;
  logic [XLEN-1:0]  skid_imm_q;
  logic [2:0]       skid_fmt_q;
  logic [TAG_W-1:0] skid_tag_q;

  logic             accept;
  logic             main_load;

  assign instr    = bus.i_instr;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Decode to a 32-bit value whose bit 31 already carries the sign for signed formats.
  always_comb begin
    dec_imm32 = 32'd0;
    dec_fmt   = FmtNone;
    unique case (opcode)
      OpLui, OpAuipc: begin
        dec_imm32 = {instr[31:12], 12'b0};
        dec_fmt   = FmtU;
      end
      OpJal: begin
        dec_imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        dec_fmt   = FmtJ;
      end
      OpJalr, OpLoad: begin
        dec_imm32 = {{20{instr[31]}}, instr[31:20]};
        dec_fmt   = FmtI;
      end
      OpImm: begin
        if (is_shift) begin
          // RV64 shamt is six bits wide; bit 25 must be ignored on RV32.
          dec_imm32 = (XLEN == 64) ? {26'd0, instr[25:20]} : {27'd0, instr[24:20]};
          dec_fmt   = FmtZ;
        end else begin
          dec_imm32 = {{20{instr[31]}}, instr[31:20]};
          dec_fmt   = FmtI;
        end
      end
      OpImm32: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            dec_imm32 = {27'd0, instr[24:20]};
            dec_fmt   = FmtZ;
          end else begin
            dec_imm32 = {{20{instr[31]}}, instr[31:20]};
            dec_fmt   = FmtI;
          end
        end
      end
      OpStore: begin
        dec_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec_fmt   = FmtS;
      end
      OpBranch: begin
        dec_imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        dec_fmt   = FmtB;
      end
      OpSystem: begin
        if (funct3[2]) begin
          dec_imm32 = {27'd0, instr[19:15]};
          dec_fmt   = FmtZ;
        end
      end
      default: begin
        dec_imm32 = 32'd0;
        dec_fmt   = FmtNone;
      end
    endcase
  end

  // Widen to XLEN; Z/NONE values have bit 31 clear so replication zero-extends them.
  if (XLEN == 64) begin : g_xlen64
    assign dec_imm = {{(XLEN-32){dec_imm32[31]}}, dec_imm32};
  end else begin : g_xlen32
    assign dec_imm = dec_imm32;
  end

  assign accept    = bus.i_valid && !skid_valid_q;
  assign main_load = !main_valid_q || bus.i_ready;

  // Main register and skid entry; the skid always drains before new input reaches main.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_fmt_q   <= FmtNone;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FmtNone;
      skid_tag_q   <= '0;
    end else if (i_flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (main_load) begin
      // accept is impossible while the skid is full, so at most one source is live.
      main_valid_q <= skid_valid_q || accept;
      skid_valid_q <= 1'b0;
      if (skid_valid_q) begin
        main_imm_q <= skid_imm_q;
        main_fmt_q <= skid_fmt_q;
        main_tag_q <= skid_tag_q;
      end else if (accept) begin
        main_imm_q <= dec_imm;
        main_fmt_q <= dec_fmt;
        main_tag_q <= bus.i_tag;
      end
    end else if (accept) begin
      skid_valid_q <= 1'b1;
      skid_imm_q   <= dec_imm;
      skid_fmt_q   <= dec_fmt;
      skid_tag_q   <= bus.i_tag;
    end
  end

  // Outputs are pure register reads.
  assign bus.o_ready = !skid_valid_q;
  assign bus.o_valid = main_valid_q;
  assign bus.o_imm   = main_imm_q;
  assign bus.o_fmt   = main_fmt_q;
  assign bus.o_tag   = main_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one RV32 and one RV64 instance on a shared clock.
module tb_imm_gen_pipe;

  logic clk;
  logic rst_n;
  logic flush;

  int n_tests = 0;
  int n_fail  = 0;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus_a ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus_b ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .bus     (bus_a)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .bus     (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One beat into both instances with the sink always ready; check one cycle later.
  task automatic single(input string name, input logic [31:0] instr, input logic [31:0] tag,
                        input logic [63:0] e32, input logic [2:0] f32,
                        input logic [63:0] e64, input logic [2:0] f64);
    @(negedge clk);
    bus_a.i_valid = 1'b1; bus_a.i_instr = instr; bus_a.i_tag = tag;
    bus_b.i_valid = 1'b1; bus_b.i_instr = instr; bus_b.i_tag = tag;
    @(negedge clk);
    bus_a.i_valid = 1'b0;
    bus_b.i_valid = 1'b0;
    check_eq({name, "_v32"},   64'(bus_a.o_valid), 64'd1);
    check_eq({name, "_imm32"}, 64'(bus_a.o_imm),   e32);
    check_eq({name, "_fmt32"}, 64'(bus_a.o_fmt),   64'(f32));
    check_eq({name, "_tag32"}, 64'(bus_a.o_tag),   64'(tag));
    check_eq({name, "_v64"},   64'(bus_b.o_valid), 64'd1);
    check_eq({name, "_imm64"}, bus_b.o_imm,        e64);
    check_eq({name, "_fmt64"}, 64'(bus_b.o_fmt),   64'(f64));
  endtask

  // Present an addi whose immediate equals the tag on the RV32 instance.
  task automatic drive_a(input logic v, input logic [31:0] tag);
    bus_a.i_valid = v;
    bus_a.i_instr = {tag[11:0], 20'h00093};
    bus_a.i_tag   = tag;
  endtask

  task automatic expect_a(input string name, input logic v, input logic r,
                          input logic [31:0] tag);
    check_eq({name, "_valid"}, 64'(bus_a.o_valid), 64'(v));
    check_eq({name, "_ready"}, 64'(bus_a.o_ready), 64'(r));
    if (v) begin
      check_eq({name, "_tag"}, 64'(bus_a.o_tag), 64'(tag));
      check_eq({name, "_imm"}, 64'(bus_a.o_imm), 64'(tag));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus_a.i_valid = 1'b0; bus_a.i_instr = '0; bus_a.i_tag = '0; bus_a.i_ready = 1'b1;
    bus_b.i_valid = 1'b0; bus_b.i_instr = '0; bus_b.i_tag = '0; bus_b.i_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 64'(bus_a.o_valid), 64'd0);
    check_eq("rst_imm",   64'(bus_a.o_imm),   64'd0);
    check_eq("rst_fmt",   64'(bus_a.o_fmt),   64'd0);
    check_eq("rst_tag",   64'(bus_a.o_tag),   64'd0);
    check_eq("rst_ready", 64'(bus_a.o_ready), 64'd1);
    check_eq("rst_imm64", bus_b.o_imm,        64'd0);
    rst_n = 1'b1;

    // Decode vectors: name, instr, tag, RV32 imm/fmt, RV64 imm/fmt.
    single("addi", 32'hFFF00093, 32'hA001, 64'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1);
    single("beq",  32'hFE000EE3, 32'hA002, 64'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3);
    single("lui",  32'h800000B7, 32'hA003, 64'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4);
    single("srai", 32'h4030D093, 32'hA004, 64'h3,        3'd6, 64'h3,                3'd6);
    single("csri", 32'hF01FD073, 32'hA005, 64'h1F,       3'd6, 64'h1F,               3'd6);
    single("op32", 32'h0000001B, 32'hA006, 64'h0,        3'd0, 64'h0,                3'd1);
    single("jal",  32'hFF9FF06F, 32'hA007, 64'hFFFFFFF8, 3'd5, 64'hFFFFFFFFFFFFFFF8, 3'd5);
    single("sw",   32'hFE112E23, 32'hA008, 64'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2);
    single("lw",   32'h00812083, 32'hA009, 64'h8,        3'd1, 64'h8,                3'd1);
    single("ecal", 32'h00000073, 32'hA00A, 64'h0,        3'd0, 64'h0,                3'd0);
    single("sl32", 32'h02009093, 32'hA00B, 64'h0,        3'd6, 64'h20,               3'd6);
    single("slw",  32'h0210909B, 32'hA00C, 64'h0,        3'd0, 64'h1,                3'd6);

    // Back-pressure: sink stalls for three edges while tags 1..4 are offered.
    @(negedge clk);
    bus_a.i_ready = 1'b0;
    drive_a(1'b1, 32'd1);
    @(negedge clk); expect_a("st1", 1'b1, 1'b1, 32'd1); drive_a(1'b1, 32'd2);
    @(negedge clk); expect_a("st2", 1'b1, 1'b0, 32'd1); drive_a(1'b1, 32'd3);
    @(negedge clk); expect_a("st3", 1'b1, 1'b0, 32'd1); bus_a.i_ready = 1'b1;
    @(negedge clk); expect_a("st4", 1'b1, 1'b1, 32'd2);
    @(negedge clk); expect_a("st5", 1'b1, 1'b1, 32'd3); drive_a(1'b1, 32'd4);
    @(negedge clk); expect_a("st6", 1'b1, 1'b1, 32'd4); drive_a(1'b0, 32'd0);
    @(negedge clk); expect_a("st7", 1'b0, 1'b1, 32'd0);

    // Flush with both entries full; a beat offered during the flush must vanish.
    bus_a.i_ready = 1'b0;
    drive_a(1'b1, 32'd5);
    @(negedge clk); drive_a(1'b1, 32'd6);
    @(negedge clk); expect_a("fl_full", 1'b1, 1'b0, 32'd5);
    flush = 1'b1; drive_a(1'b1, 32'd7);
    @(negedge clk); expect_a("fl_post", 1'b0, 1'b1, 32'd0);
    flush = 1'b0; bus_a.i_ready = 1'b1; drive_a(1'b1, 32'd9);
    @(negedge clk); expect_a("fl_new", 1'b1, 1'b1, 32'd9); drive_a(1'b0, 32'd0);
    @(negedge clk); expect_a("fl_idle", 1'b0, 1'b1, 32'd0);

    // Reset together with flush mid-stream, then normal latency resumes.
    drive_a(1'b1, 32'd10);
    @(negedge clk); expect_a("rs_pre", 1'b1, 1'b1, 32'd10);
    rst_n = 1'b0; flush = 1'b1; drive_a(1'b1, 32'd11);
    @(negedge clk);
    check_eq("rs_valid", 64'(bus_a.o_valid), 64'd0);
    check_eq("rs_imm",   64'(bus_a.o_imm),   64'd0);
    check_eq("rs_fmt",   64'(bus_a.o_fmt),   64'd0);
    check_eq("rs_tag",   64'(bus_a.o_tag),   64'd0);
    check_eq("rs_ready", 64'(bus_a.o_ready), 64'd1);
    rst_n = 1'b1; flush = 1'b0; drive_a(1'b1, 32'd12);
    @(negedge clk); expect_a("rs_new", 1'b1, 1'b1, 32'd12); drive_a(1'b0, 32'd0);
    @(negedge clk); expect_a("rs_idle", 1'b0, 1'b1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
